// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes a - b - borrow_in one bit
// per clock, LSB first, through a single full-subtractor cell whose borrow is
// carried from bit to bit in a flop.
//
// Handshake: start is accepted in IDLE or DONE. busy is high for the WIDTH
// cycles of the run, and done pulses for one cycle when the result registers
// update. diff/borrow_out/overflow hold the last completed result and change
// only on the completion edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request (ignored while busy)
//   a          minuend, latched on an accepted start
//   b          subtrahend, latched on an accepted start
//   borrow_in  initial borrow, latched on an accepted start
//   busy       high while the serial run is in progress
//   done       one-cycle pulse when a new result is valid
//   diff       result of the last completed operation
//   borrow_out final borrow (unsigned a < b + borrow_in)
//   overflow   signed overflow of the last completed operation
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic [WIDTH-1:0] aShift;
  logic [WIDTH-1:0] bShift;
  logic [WIDTH-1:0] resShift;
  logic             borFlop;
  logic [CNT_W-1:0] bitCnt;

  logic accept;
  logic lastBit;
  logic aBit;
  logic bBit;
  logic dBit;
  logic borNext;

  // New operands are only taken when no run is in flight.
  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign lastBit = (state == RUN) && (bitCnt == LAST_BIT);

  // Full-subtractor cell on the current LSBs of the operand shifters.
  assign aBit    = aShift[0];
  assign bBit    = bShift[0];
  assign dBit    = aBit ^ bBit ^ borFlop;
  assign borNext = (~aBit & bBit) | (~(aBit ^ bBit) & borFlop);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastBit) stateNext = DONE;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Serial datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aShift     <= '0;
      bShift     <= '0;
      resShift   <= '0;
      borFlop    <= 1'b0;
      bitCnt     <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      aShift  <= a;
      bShift  <= b;
      borFlop <= borrow_in;
      bitCnt  <= '0;
    end else if (state == RUN) begin
      aShift   <= aShift >> 1;
      bShift   <= bShift >> 1;
      borFlop  <= borNext;
      resShift <= {dBit, resShift[WIDTH-1:1]};
      bitCnt   <= bitCnt + 1'b1;
      if (lastBit) begin
        // On the last bit the shifter LSBs are the operand MSBs and dBit is
        // the result MSB, so the overflow rule can use them directly.
        diff       <= {dBit, resShift[WIDTH-1:1]};
        borrow_out <= borNext;
        overflow   <= (aBit != bBit) && (dBit != aBit);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t expQ[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t e;
    int r;
    int sr;
    r = int'(av) - int'(bv) - int'(bi);
    e.d = r[W-1:0];
    e.bo = (r < 0);
    sr = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    e.ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    e.acc = 0;
    return e;
  endfunction

  // Monitor / scoreboard
  initial begin : monitor
    logic [W-1:0] lastDiff;
    logic         lastBo;
    logic         lastOv;
    int           busyRun;
    exp_t         e;
    lastDiff = '0;
    lastBo = 1'b0;
    lastOv = 1'b0;
    busyRun = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lastDiff = '0;
        lastBo = 1'b0;
        lastOv = 1'b0;
        busyRun = 0;
      end else begin
        if (!done) begin
          checks++;
          if (diff !== lastDiff || borrow_out !== lastBo || overflow !== lastOv) begin
            errors++;
            $display("FAIL hold t=%0t: diff=%h bo=%b ov=%b expected %h %b %b",
                     $time, diff, borrow_out, overflow, lastDiff, lastBo, lastOv);
          end
        end
        if (busy) busyRun++;
        if (done) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done t=%0t: diff=%h, no operation outstanding", $time, diff);
          end else begin
            e = expQ.pop_front();
            if (diff !== e.d || borrow_out !== e.bo || overflow !== e.ov) begin
              errors++;
              $display("FAIL result t=%0t: diff=%h bo=%b ov=%b expected diff=%h bo=%b ov=%b",
                       $time, diff, borrow_out, overflow, e.d, e.bo, e.ov);
            end else begin
              $display("op done t=%0t: diff=%h bo=%b ov=%b", $time, diff, borrow_out, overflow);
            end
            checks++;
            if (cycleCnt - e.acc != W) begin
              errors++;
              $display("FAIL latency: %0d cycles, expected %0d", cycleCnt - e.acc, W);
            end
            checks++;
            if (busyRun != W || busy !== 1'b0) begin
              errors++;
              $display("FAIL busy_len: busy high %0d cycles (busy now %b), expected %0d then 0",
                       busyRun, busy, W);
            end
            lastDiff = e.d;
            lastBo = e.bo;
            lastOv = e.ov;
          end
          busyRun = 0;
        end
      end
    end
  end

  // Issue one operation; returns on the negedge where done is seen (plus idle cycles).
  task automatic doOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input int idle, input bit midStart);
    exp_t e;
    int n;
    start = 1'b1;
    a = av;
    b = bv;
    borrow_in = bi;
    @(posedge clk);
    #1;
    e = model(av, bv, bi);
    e.acc = cycleCnt;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    borrow_in = 1'($urandom);
    n = 0;
    while (!done && n < W + 4) begin
      start = (midStart && n == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for a=%h b=%h bin=%b", av, bv, bi);
    end
    repeat (idle) @(negedge clk);
  endtask

  task automatic checkCleared(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b diff=%h bo=%b ov=%b, expected all 0",
               tag, busy, done, diff, borrow_out, overflow);
    end else begin
      $display("%s: outputs cleared", tag);
    end
  endtask

  initial begin : stim
    #1 rst_n = 1'b0;
    #2;
    checkCleared("reset_state");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    doOp(8'h05, 8'h03, 1'b0, 2, 1'b0);
    doOp(8'h03, 8'h05, 1'b0, 1, 1'b0);
    doOp(8'h80, 8'h01, 1'b0, 0, 1'b0);
    doOp(8'h7F, 8'hFF, 1'b0, 1, 1'b0);
    doOp(8'h00, 8'h00, 1'b1, 1, 1'b0);
    doOp(8'hFF, 8'hFF, 1'b0, 1, 1'b0);
    doOp(8'h80, 8'h7F, 1'b1, 1, 1'b0);
    // start pulsed mid-run is ignored
    doOp(8'h05, 8'h03, 1'b0, 1, 1'b1);
    // back-to-back: start presented during DONE
    doOp(8'h40, 8'h10, 1'b0, 0, 1'b0);
    doOp(8'h10, 8'h40, 1'b1, 1, 1'b0);

    // Abort a run with an asynchronous reset around bit 4
    start = 1'b1;
    a = 8'hA5;
    b = 8'h3C;
    borrow_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkCleared("reset_mid_run");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    doOp(8'h10, 8'h01, 1'b0, 1, 1'b0);

    // Random operations with random gaps (0 exercises back-to-back)
    for (int i = 0; i < 1000; i++) begin
      doOp(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d operations never completed, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
